// File: rtl/oqpsk_pkg.sv
// Shared constants, FSM state type and frame builder for the OQPSK DAC feeder.
// Ports: none (package).
// Frame: {channel, 2'b00, offset-binary sample}, 16 bits, MSB first.
package oqpsk_pkg;

  localparam int   W       = 13;
  localparam int   FRAME_W = 16;
  localparam logic CH_I    = 1'b0;
  localparam logic CH_Q    = 1'b1;
  localparam int   GAP_LEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LAT,
    SHIFT_I,
    GAP_I,
    SHIFT_Q,
    GAP_Q
  } state_t;

  // Two's complement -> offset binary is just an MSB flip.
  function automatic logic [FRAME_W-1:0] make_frame(input logic ch, input logic [W-1:0] s);
    return {ch, 2'b00, ~s[W-1], s[W-2:0]};
  endfunction

endpackage

// File: rtl/oqpsk_dac_feeder_if.sv
// Modulator sample path plus DAC serial link of the OQPSK DAC feeder.
// master = feeder side (drives REQ_SAMPLE and the DAC lines, reads I/Q samples).
// slave  = modulator/DAC side.
interface oqpsk_dac_feeder_if;
  import oqpsk_pkg::*;

  logic         REQ_SAMPLE;
  logic [W-1:0] I_IN;
  logic [W-1:0] Q_IN;
  logic         DAC_SCLK;
  logic         DAC_CS_N;
  logic         DAC_SDO;

  modport master (
    output REQ_SAMPLE, DAC_SCLK, DAC_CS_N, DAC_SDO,
    input  I_IN, Q_IN
  );

  modport slave (
    input  REQ_SAMPLE, DAC_SCLK, DAC_CS_N, DAC_SDO,
    output I_IN, Q_IN
  );

endinterface

// File: rtl/oqpsk_spi_shifter.sv
// SPI frame shifter: loads a 16-bit word on start and shifts it out MSB first.
// Ports: CLK/RST (sync, active low), start/word load, sclk/cs_n/sdo link, done.
// Frame takes 32 cycles (2 per bit); done is high on the last frame cycle.
module oqpsk_spi_shifter
  import oqpsk_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [FRAME_W-1:0] word,
  output logic               sclk,
  output logic               cs_n,
  output logic               sdo,
  output logic               done
);

  localparam int PW = $clog2(2 * FRAME_W);
  localparam logic [PW-1:0] LAST = PW'(2 * FRAME_W - 1);

  logic               active;
  logic [PW-1:0]      phase;
  logic [FRAME_W-1:0] sh;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      active <= 1'b0;
      phase  <= '0;
      sh     <= '0;
    end else if (start) begin
      active <= 1'b1;
      phase  <= '0;
      sh     <= word;
    end else if (active) begin
      phase <= phase + PW'(1);
      // Advance to the next bit only after the SCLK-high half has passed.
      if (phase[0]) sh <= {sh[FRAME_W-2:0], 1'b0};
      if (phase == LAST) active <= 1'b0;
    end
  end

  assign cs_n = ~active;
  assign sclk = active & phase[0];
  assign sdo  = active & sh[FRAME_W-1];
  assign done = active && (phase == LAST);

endmodule

// File: rtl/oqpsk_dac_feeder.sv
// OQPSK DAC feeder: paces the modulator, captures I/Q, serialises I then Q frames.
// Ports: CLK/RST (sync, active low), EN, CLR_OVR, bus (sample req/in + DAC link),
//        BUSY, OVR (sticky), OVR_CNT (saturating overrun count).
module oqpsk_dac_feeder
  import oqpsk_pkg::*;
#(
  parameter int DIV = 80,
  parameter int LAT = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               CLR_OVR,
  oqpsk_dac_feeder_if.master bus,
  output logic               BUSY,
  output logic               OVR,
  output logic [7:0]         OVR_CNT
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW = $clog2(LAT + 1);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  state_t             state, nstate;
  logic [CW-1:0]      div_cnt;
  logic [LW-1:0]      lat_cnt;
  logic [GW-1:0]      gap_cnt;
  logic [W-1:0]       q_cap;
  logic               tick;
  logic               capture;
  logic               gap_last;
  logic               sh_start;
  logic               sh_done;
  logic [FRAME_W-1:0] sh_word;

  // Sample-rate divider; the request goes out regardless of FSM state.
  always_ff @(posedge CLK) begin
    if (!RST || !EN)                   div_cnt <= '0;
    else if (div_cnt == CW'(DIV - 1)) div_cnt <= '0;
    else                               div_cnt <= div_cnt + CW'(1);
  end

  assign tick           = RST && EN && (div_cnt == CW'(DIV - 1));
  assign bus.REQ_SAMPLE = tick;
  assign gap_last       = (gap_cnt == GW'(GAP_LEN - 1));

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= nstate;
  end

  // The I sample is captured straight into the shifter on the capture edge;
  // only Q needs a holding register until its frame starts.
  always_comb begin
    nstate   = state;
    capture  = 1'b0;
    sh_start = 1'b0;
    sh_word  = make_frame(CH_I, bus.I_IN);
    case (state)
      IDLE:     if (tick) nstate = WAIT_LAT;
      WAIT_LAT: if (lat_cnt == LW'(LAT - 1)) begin
                  capture  = 1'b1;
                  sh_start = 1'b1;
                  nstate   = SHIFT_I;
                end
      SHIFT_I:  if (sh_done) nstate = GAP_I;
      GAP_I:    if (gap_last) begin
                  sh_start = 1'b1;
                  sh_word  = make_frame(CH_Q, q_cap);
                  nstate   = SHIFT_Q;
                end
      SHIFT_Q:  if (sh_done) nstate = GAP_Q;
      GAP_Q:    if (gap_last) nstate = IDLE;
      default:  nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      lat_cnt <= '0;
      gap_cnt <= '0;
      q_cap   <= '0;
    end else begin
      lat_cnt <= (state == WAIT_LAT) ? lat_cnt + LW'(1) : '0;
      gap_cnt <= (state == GAP_I || state == GAP_Q) ? gap_cnt + GW'(1) : '0;
      if (capture) q_cap <= bus.Q_IN;
    end
  end

  // Overrun: a tick that finds the FSM busy. Clear has priority.
  always_ff @(posedge CLK) begin
    if (!RST || CLR_OVR) begin
      OVR     <= 1'b0;
      OVR_CNT <= '0;
    end else if (tick && state != IDLE) begin
      OVR <= 1'b1;
      if (OVR_CNT != 8'hFF) OVR_CNT <= OVR_CNT + 8'd1;
    end
  end

  assign BUSY = (state != IDLE);

  oqpsk_spi_shifter u_shifter (
    .CLK   (CLK),
    .RST   (RST),
    .start (sh_start),
    .word  (sh_word),
    .sclk  (bus.DAC_SCLK),
    .cs_n  (bus.DAC_CS_N),
    .sdo   (bus.DAC_SDO),
    .done  (sh_done)
  );

endmodule

// File: tb/tb_oqpsk_dac_feeder.sv
// Bench for oqpsk_dac_feeder: scoreboard of expected DAC words checked by a
// serial-link monitor, plus cycle-accurate directed checks of pacing/overrun.
// dut0 runs the nominal DIV=80; dut1 runs DIV=40 to provoke overruns.
module tb_oqpsk_dac_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic clr0 = 1'b0, clr1 = 1'b0;
  logic busy0, busy1, ovr0, ovr1;
  logic [7:0] ovr_cnt0, ovr_cnt1;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  oqpsk_dac_feeder_if bus0();
  oqpsk_dac_feeder_if bus1();

  oqpsk_dac_feeder #(.DIV(80), .LAT(2)) dut0 (
    .CLK(clk), .RST(rst), .EN(en0), .CLR_OVR(clr0), .bus(bus0),
    .BUSY(busy0), .OVR(ovr0), .OVR_CNT(ovr_cnt0)
  );

  oqpsk_dac_feeder #(.DIV(40), .LAT(2)) dut1 (
    .CLK(clk), .RST(rst), .EN(en1), .CLR_OVR(clr1), .bus(bus1),
    .BUSY(busy1), .OVR(ovr1), .OVR_CNT(ovr_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial-link monitor: rebuilds each frame from SDO at SCLK rising edges.
  initial begin : monitor
    int          run;
    int          nb;
    logic [15:0] w;
    logic [15:0] e;
    logic        stable;
    logic        prev_cs, prev_sclk, prev_sdo;
    run = 0; nb = 0; w = '0; stable = 1'b1;
    prev_cs = 1'b1; prev_sclk = 1'b0; prev_sdo = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        run = 0; nb = 0; w = '0; stable = 1'b1;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_sdo = 1'b0;
      end else begin
        if (!bus0.DAC_CS_N) begin
          run++;
          if (bus0.DAC_SCLK && !prev_sclk) begin
            w = {w[14:0], bus0.DAC_SDO};
            nb++;
            if (bus0.DAC_SDO !== prev_sdo || prev_cs) stable = 1'b0;
          end
        end else if (!prev_cs) begin
          check("frame_len", run, 32);
          check("frame_bits", nb, 16);
          check("bit_stable", stable, 1'b1);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_unexpected: got %0h expected no frame", w);
          end else begin
            e = exp_q.pop_front();
            check("frame_word", w, e);
          end
          run = 0; nb = 0; w = '0; stable = 1'b1;
        end
        prev_cs = bus0.DAC_CS_N; prev_sclk = bus0.DAC_SCLK; prev_sdo = bus0.DAC_SDO;
      end
    end
  end

  // One enabled period on dut0. Samples are valid only in cycle 82, so the
  // words come out right only if capture happens exactly on that edge.
  task automatic run_window(input logic [12:0] iv, input logic [12:0] qv,
                            input logic [15:0] wi, input logic [15:0] wq,
                            input int en_off, input int ncyc);
    logic exp_cs;
    exp_q.push_back(wi);
    exp_q.push_back(wq);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      en0 = (c < en_off);
      if (c == 82) begin
        bus0.I_IN = iv; bus0.Q_IN = qv;
      end else begin
        bus0.I_IN = 13'h0A5A ^ 13'(c); bus0.Q_IN = 13'h05A5 ^ 13'(c);
      end
      #1;
      exp_cs = !((c >= 83 && c <= 114) || (c >= 117 && c <= 148));
      check($sformatf("req c%0d", c), bus0.REQ_SAMPLE, (c == 80 && c < en_off));
      check($sformatf("busy c%0d", c), busy0, (c >= 81 && c <= 150));
      check($sformatf("cs_n c%0d", c), bus0.DAC_CS_N, exp_cs);
      if (exp_cs) check($sformatf("idle_lines c%0d", c), {bus0.DAC_SCLK, bus0.DAC_SDO}, 2'b00);
    end
    check("frames_drained", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus0.I_IN = '0; bus0.Q_IN = '0;
    bus1.I_IN = '0; bus1.Q_IN = '0;

    // Reset values
    repeat (3) @(negedge clk);
    en0 = 1'b1;
    #1;
    check("rst_req", bus0.REQ_SAMPLE, 1'b0);
    check("rst_sclk", bus0.DAC_SCLK, 1'b0);
    check("rst_cs_n", bus0.DAC_CS_N, 1'b1);
    check("rst_sdo", bus0.DAC_SDO, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_ovr", ovr0, 1'b0);
    check("rst_ovr_cnt", ovr_cnt0, 8'd0);
    @(negedge clk);
    en0 = 1'b0;
    rst = 1'b1;

    // Extremes: -4096 / +4095
    run_window(13'h1000, 13'h0FFF, 16'h0000, 16'h9FFF, 155, 160);
    // EN dropped mid SHIFT_I: both frames, then no further requests
    run_window(13'h0000, 13'h1FFF, 16'h1000, 16'h8FFF, 90, 250);

    // Reset during SHIFT_Q
    exp_q.push_back(16'h1FFF);
    exp_q.push_back(16'h8000);
    for (int c = 1; c <= 125; c++) begin
      @(negedge clk);
      en0 = 1'b1;
      if (c == 82) begin
        bus0.I_IN = 13'h0FFF; bus0.Q_IN = 13'h1000;
      end else begin
        bus0.I_IN = 13'h0A5A ^ 13'(c); bus0.Q_IN = 13'h05A5 ^ 13'(c);
      end
      if (c >= 120) rst = 1'b0;
      #1;
      if (c == 119) check("abort_i_done", exp_q.size(), 1);
      if (c == 120) check("abort_cs_before_edge", bus0.DAC_CS_N, 1'b0);
      if (c == 121) begin
        check("abort_cs_n", bus0.DAC_CS_N, 1'b1);
        check("abort_sclk", bus0.DAC_SCLK, 1'b0);
        check("abort_sdo", bus0.DAC_SDO, 1'b0);
        check("abort_busy", busy0, 1'b0);
        check("abort_req", bus0.REQ_SAMPLE, 1'b0);
        check("abort_ovr_cnt", ovr_cnt0, 8'd0);
        exp_q.delete();
      end
    end
    @(negedge clk);
    en0 = 1'b0;
    rst = 1'b1;

    // Normal restart after reset
    run_window(13'h0000, 13'h1FFF, 16'h1000, 16'h8FFF, 155, 160);
    check("nominal_no_ovr", ovr0, 1'b0);
    check("nominal_ovr_cnt", ovr_cnt0, 8'd0);

    // DIV=40: overrun on every second tick, n-th overrun at cycle 80*n
    for (int c = 1; c <= 20801; c++) begin
      @(negedge clk);
      en1  = 1'b1;
      clr1 = (c == 20720);
      #1;
      if (c == 40)    check("ovr_first_req", bus1.REQ_SAMPLE, 1'b1);
      if (c == 41)    check("ovr_first_busy", busy1, 1'b1);
      if (c == 80)    check("ovr_before", ovr1, 1'b0);
      if (c == 81)    check("ovr_set", {ovr1, ovr_cnt1}, {1'b1, 8'd1});
      if (c == 121)   check("ovr_cnt_hold", ovr_cnt1, 8'd1);
      if (c == 161)   check("ovr_cnt2", ovr_cnt1, 8'd2);
      if (c == 20321) check("ovr_cnt254", ovr_cnt1, 8'd254);
      if (c == 20401) check("ovr_cnt255", ovr_cnt1, 8'd255);
      if (c == 20641) check("ovr_sat", {ovr1, ovr_cnt1}, {1'b1, 8'd255});
      if (c == 20721) check("clr_wins", {ovr1, ovr_cnt1}, {1'b0, 8'd0});
      if (c == 20760) check("clr_stays", {ovr1, ovr_cnt1}, {1'b0, 8'd0});
      if (c == 20801) check("ovr_after_clr", {ovr1, ovr_cnt1}, {1'b1, 8'd1});
    end
    en1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
